dst_tag_expand4multicast_pipe: RTL and testbench
================================================

// Module: dst_tag_expand4multicast_pipe
// PURPOSE
//  Pipelined, parametrised successor of the multicast destination-tag expander. Per input lane, converts a
//  {mask, index} destination (mask bit = 1 -> "either value", i.e. multicast on that level) into the full
//  2-bit fork-tag set for every node of a log2(NUM_OUTPUT_DATA)-level binary distribution tree. Data travels
//  alongside the tags. One register stage per tree level, with a valid/ready handshake. Sits between the
//  input buffers and the distribution-tree switches.
// PARAMETERS
//  DATA_WIDTH       32  payload width per lane
//  NUM_INPUT_DATA   8   number of lanes (2^n)
//  NUM_OUTPUT_DATA  8   tree leaves (2^n, >=2)
//  DST_IDX_WIDTH    $clog2(NUM_OUTPUT_DATA)  index and mask width, and pipeline depth (localparam)
//  TAG_BUS_WIDTH    (NUM_OUTPUT_DATA-1)*2    tag bits per lane (localparam)
// PORTS
//  clk         in   1                                clock
//  rst         in   1                                synchronous, active-high reset
//  i_en        in   1                                global enable; 0 freezes the whole pipeline
//  i_valid     in   NUM_INPUT_DATA                   per-lane valid
//  i_data_bus  in   NUM_INPUT_DATA*DATA_WIDTH        lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//  i_cmd       in   NUM_INPUT_DATA*2*DST_IDX_WIDTH   lane k = {mask, idx}; idx in the LSBs
//  i_ready     out  1                                stage 0 can accept (includes i_en)
//  o_valid     out  NUM_INPUT_DATA                   per-lane output valid
//  o_data_bus  out  NUM_INPUT_DATA*DATA_WIDTH        delayed payload; 0 on invalid lanes
//  o_tag_bus   out  NUM_INPUT_DATA*TAG_BUS_WIDTH     lane k: node n tag at [k*TAG_BUS_WIDTH+2n +: 2]
//  o_ready     in   1                                downstream accepts
// BEHAVIOUR
//  - Node tags: 2'b00 none, 2'b01 low child, 2'b10 high child, 2'b11 both. Heap order: node at level l,
//    position p = 2^l-1+p. Root is node 0 at the LSBs.
//  - Level l uses bit b = DST_IDX_WIDTH-1-l. Active node: mask[b] ? 11 : (idx[b] ? 10 : 01).
//    Root is active iff the lane is valid. A child is active iff the parent tag selects it. Inactive = 00.
//  - Stage s (0..DST_IDX_WIDTH-1) registers the level-s tags and carries valid, data, idx, mask and earlier tags.
//  - Stage transfer: a stage holds a beat when any of its lane valids is set. Stage s loads when i_en &&
//    (stage s empty || stage s+1 loads). The last stage loads when i_en && (!any o_valid || o_ready).
//    i_ready = i_en && stage-0 load condition.
//  - Input accepted when i_ready && |i_valid. All lanes move together as one beat; lane valids are independent.
//  - Latency: exactly DST_IDX_WIDTH cycles with no stall. Throughput: 1 beat/cycle.
//  - Stall: with o_ready=0 and o_valid!=0, outputs hold stable and bubbles upstream are compressed.
//    When full, i_ready=0.
//  - i_en=0: no register changes, i_ready=0, outputs hold.
//  - Invalid lane: data and tags are zeroed at capture (dummy data = {DATA_WIDTH{1'b0}}).
//  - Reset, including mid-flight: all valids=0, all data/tag registers=0, so o_valid=0, o_data_bus=0,
//    o_tag_bus=0 and i_ready=0 during rst. Beats in flight are discarded. i_ready returns 1 the cycle after
//    rst deasserts, provided i_en=1.
//  - mask all ones: broadcast, all tags 11. Upper i_cmd bits are ignored beyond DST_IDX_WIDTH per field.
// STRUCTURE
//  - Shared package/header: TAG_NONE/TAG_LOW/TAG_HIGH/TAG_BOTH, and the node-index function 2^l-1+p.
//  - Sub-module tree_level_tag_gen (combinational, parametrised by level): one lane's parent tags plus
//    idx/mask bit produce the 2^l level tags. It is instantiated per lane per stage inside a generate loop.
//    The pipeline registers and the ready chain stay in the top module.
// TESTING (NUM_INPUT_DATA=8, NUM_OUTPUT_DATA=8, DATA_WIDTH=32)
//  1 Lane0 idx=5 mask=0, data=0xA5A5A5A5 -> 3 cycles later o_valid[0]=1, lane0 tags=14'h0812, data echoed;
//    other lanes tags=0, data=0.
//  2 Lane3 idx=0 mask=3'b001 -> lane3 tags=14'h00C5; lane3 idx=x mask=3'b111 -> 14'h3FFF.
//  3 Back-to-back beats on 8 cycles with o_ready=1 -> 8 outputs on consecutive cycles, in order, i_ready=1.
//  4 Fill the pipeline, hold o_ready=0 for 5 cycles -> outputs stable, i_ready=0 after 3 accepts.
//    Release -> no loss or duplication.
//  5 i_en=0 for 4 cycles mid-stream -> i_ready=0, all outputs frozen; resumes with correct order.
//  6 rst pulse with 2 beats in flight -> next cycle o_valid=0, o_tag_bus=0, o_data_bus=0; later beats unaffected.

Source files
------------

// File: rtl/dst_tag_expand4multicast_pipe_pkg.sv
// Shared definitions for the multicast destination-tag expander: fork-tag
// encodings and heap-order node numbering of the binary distribution tree.
package dst_tag_expand4multicast_pipe_pkg;

    // Fork tag of one tree node: which children receive the beat
    localparam logic [1:0] TAG_NONE = 2'b00;
    localparam logic [1:0] TAG_LOW  = 2'b01;
    localparam logic [1:0] TAG_HIGH = 2'b10;
    localparam logic [1:0] TAG_BOTH = 2'b11;

    // Heap-order index of the node at tree level `level`, position `pos`.
    // The root is node 0; level l starts at node 2^l - 1.
    function automatic int node_index(input int level, input int pos);
        return (1 << level) - 1 + pos;
    endfunction

endpackage

// File: rtl/dst_tag_expand4multicast_pipe_tree_level_tag_gen.sv
// Combinational tag generator for one lane at one tree level. Each of the
// 2^LEVEL nodes of the level is enabled by one select bit taken from its
// parent's tag (or by the lane valid at the root). An enabled node forks
// according to the level's mask/index bit; a disabled node carries no tag.
module tree_level_tag_gen
    import dst_tag_expand4multicast_pipe_pkg::*;
#(
    parameter int LEVEL = 0
) (
    input  logic [(1 << LEVEL)-1:0]     i_sel,
    input  logic                        i_idx_bit,
    input  logic                        i_mask_bit,
    output logic [2*(1 << LEVEL)-1:0]   o_tags
);

    localparam int NODES = 1 << LEVEL;

    logic [1:0] fork_tag;

    // All active nodes on a level fork the same way: the level consumes one
    // destination bit, and the mask bit widens the choice to both children.
    always_comb begin
        fork_tag = TAG_NONE;
        if (i_mask_bit) begin
            fork_tag = TAG_BOTH;
        end else if (i_idx_bit) begin
            fork_tag = TAG_HIGH;
        end else begin
            fork_tag = TAG_LOW;
        end
    end

    // Select bit p enables node p of this level (flattened parent tags line
    // up so that bit p is exactly the parent's pointer to child p).
    always_comb begin
        o_tags = '0;
        for (int p = 0; p < NODES; p++) begin
            o_tags[2*p +: 2] = i_sel[p] ? fork_tag : TAG_NONE;
        end
    end

endmodule

// File: rtl/dst_tag_expand4multicast_pipe.sv
// Pipelined multicast destination-tag expander. Each lane's {mask, idx}
// destination is expanded into the fork tags of every node of a binary
// distribution tree, one tree level per register stage. Data rides along
// with the tags. All lanes move together as one beat under a valid/ready
// chain that compresses bubbles while the output is stalled.
module dst_tag_expand4multicast_pipe
    import dst_tag_expand4multicast_pipe_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_INPUT_DATA  = 8,
    parameter int NUM_OUTPUT_DATA = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  i_en,
    input  logic [NUM_INPUT_DATA-1:0]                             i_valid,
    input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]                  i_data_bus,
    input  logic [NUM_INPUT_DATA*2*$clog2(NUM_OUTPUT_DATA)-1:0]   i_cmd,
    output logic                                                  i_ready,
    output logic [NUM_INPUT_DATA-1:0]                             o_valid,
    output logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]                  o_data_bus,
    output logic [NUM_INPUT_DATA*(NUM_OUTPUT_DATA-1)*2-1:0]       o_tag_bus,
    input  logic                                                  o_ready
);

    localparam int DST_IDX_WIDTH = $clog2(NUM_OUTPUT_DATA);
    localparam int TAG_BUS_WIDTH = (NUM_OUTPUT_DATA - 1) * 2;
    localparam int NI            = NUM_INPUT_DATA;
    localparam int DW            = DATA_WIDTH;
    localparam int IW            = DST_IDX_WIDTH;
    localparam int TW            = TAG_BUS_WIDTH;

    // Per-stage register contents, flattened stage-major so each stage can
    // read its predecessor without hierarchical references.
    logic [IW-1:0]        load;
    logic [IW*NI-1:0]     vld_pipe;
    logic [IW*NI*DW-1:0]  data_pipe;
    logic [IW*NI*IW-1:0]  idx_pipe;
    logic [IW*NI*IW-1:0]  mask_pipe;
    logic [IW*NI*TW-1:0]  tags_pipe;

    logic [NI*DW-1:0]     in_data;
    logic [NI*IW-1:0]     in_idx;
    logic [NI*IW-1:0]     in_mask;
    logic                 unused_last_cmd;

    // Split the command bus into index/mask fields and blank the payload of
    // invalid lanes so bubbles and dummy lanes are all-zero downstream.
    always_comb begin
        in_data = '0;
        in_idx  = '0;
        in_mask = '0;
        for (int k = 0; k < NI; k++) begin
            in_data[k*DW +: DW] = i_valid[k] ? i_data_bus[k*DW +: DW] : '0;
            in_idx[k*IW +: IW]  = i_cmd[k*2*IW +: IW];
            in_mask[k*IW +: IW] = i_cmd[k*2*IW + IW +: IW];
        end
    end

    // Ready chain, evaluated from the output back to stage 0: a stage may
    // load when it is empty or when the stage after it is loading too.
    always_comb begin
        logic nxt;
        load = '0;
        nxt  = i_en && (!(|vld_pipe[(IW-1)*NI +: NI]) || o_ready);
        load[IW-1] = nxt;
        for (int s = IW - 2; s >= 0; s--) begin
            nxt     = i_en && (!(|vld_pipe[s*NI +: NI]) || nxt);
            load[s] = nxt;
        end
    end

    assign i_ready = load[0] && !rst;

    for (genvar s = 0; s < IW; s++) begin : g_stage
        localparam int NODES   = 1 << s;
        localparam int LVL_LSB = 2 * node_index(s, 0);

        logic [NI-1:0]      src_vld;
        logic [NI*DW-1:0]   src_data;
        logic [NI*IW-1:0]   src_idx;
        logic [NI*IW-1:0]   src_mask;
        logic [NI*TW-1:0]   src_tags;
        logic [NI*TW-1:0]   tags_with_lvl;
        logic [2*NODES-1:0] lvl_tags [NI];

        logic [NI-1:0]      vld_d,  vld_q;
        logic [NI*DW-1:0]   data_d, data_q;
        logic [NI*IW-1:0]   idx_d,  idx_q;
        logic [NI*IW-1:0]   mask_d, mask_q;
        logic [NI*TW-1:0]   tags_d, tags_q;

        if (s == 0) begin : g_from_input
            assign src_vld  = i_valid;
            assign src_data = in_data;
            assign src_idx  = in_idx;
            assign src_mask = in_mask;
            assign src_tags = '0;
        end else begin : g_from_prev
            assign src_vld  = vld_pipe[(s-1)*NI +: NI];
            assign src_data = data_pipe[(s-1)*NI*DW +: NI*DW];
            assign src_idx  = idx_pipe[(s-1)*NI*IW +: NI*IW];
            assign src_mask = mask_pipe[(s-1)*NI*IW +: NI*IW];
            assign src_tags = tags_pipe[(s-1)*NI*TW +: NI*TW];
        end

        for (genvar k = 0; k < NI; k++) begin : g_lane
            logic [NODES-1:0] sel;

            if (s == 0) begin : g_root
                assign sel = src_vld[k];
            end else begin : g_child
                assign sel = src_tags[k*TW + 2*node_index(s-1, 0) +: NODES];
            end

            tree_level_tag_gen #(
                .LEVEL      (s)
            ) u_tag_gen (
                .i_sel      (sel),
                .i_idx_bit  (src_idx[k*IW + IW-1-s]),
                .i_mask_bit (src_mask[k*IW + IW-1-s]),
                .o_tags     (lvl_tags[k])
            );
        end

        // Insert this level's freshly computed tags above the earlier levels
        always_comb begin
            tags_with_lvl = src_tags;
            for (int k = 0; k < NI; k++) begin
                tags_with_lvl[k*TW + LVL_LSB +: 2*NODES] = lvl_tags[k];
            end
        end

        // Take the upstream beat (or bubble) when the chain lets this stage
        // load; otherwise hold, which also covers the global freeze.
        always_comb begin
            vld_d  = vld_q;
            data_d = data_q;
            idx_d  = idx_q;
            mask_d = mask_q;
            tags_d = tags_q;
            if (load[s]) begin
                vld_d  = src_vld;
                data_d = src_data;
                idx_d  = src_idx;
                mask_d = src_mask;
                tags_d = tags_with_lvl;
            end
        end

        // Stage register; reset clears payload as well so no stale tag can
        // reach the tree switches after a mid-flight reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= '0;
                data_q <= '0;
                idx_q  <= '0;
                mask_q <= '0;
                tags_q <= '0;
            end else begin
                vld_q  <= vld_d;
                data_q <= data_d;
                idx_q  <= idx_d;
                mask_q <= mask_d;
                tags_q <= tags_d;
            end
        end

        assign vld_pipe[s*NI +: NI]            = vld_q;
        assign data_pipe[s*NI*DW +: NI*DW]     = data_q;
        assign idx_pipe[s*NI*IW +: NI*IW]      = idx_q;
        assign mask_pipe[s*NI*IW +: NI*IW]     = mask_q;
        assign tags_pipe[s*NI*TW +: NI*TW]     = tags_q;
    end

    assign o_valid    = vld_pipe[(IW-1)*NI +: NI];
    assign o_data_bus = data_pipe[(IW-1)*NI*DW +: NI*DW];
    assign o_tag_bus  = tags_pipe[(IW-1)*NI*TW +: NI*TW];

    // The final stage's destination fields have no further consumer
    assign unused_last_cmd = ^{idx_pipe[(IW-1)*NI*IW +: NI*IW],
                               mask_pipe[(IW-1)*NI*IW +: NI*IW]};

endmodule

// File: tb/tb_dst_tag_expand4multicast_pipe.sv
// Self-checking bench for dst_tag_expand4multicast_pipe: a path-matching
// tree model plus an in-flight beat queue predicts every output cycle.
module tb_dst_tag_expand4multicast_pipe;

    localparam int DW  = 32;
    localparam int NI  = 8;
    localparam int NO  = 8;
    localparam int D   = 3;
    localparam int TBW = 14;
    localparam int CW  = NI * 2 * D;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_en;
    logic              o_ready;
    logic              i_ready;
    logic [NI-1:0]     i_valid;
    logic [NI-1:0]     o_valid;
    logic [NI*DW-1:0]  i_data_bus;
    logic [NI*DW-1:0]  o_data_bus;
    logic [CW-1:0]     i_cmd;
    logic [NI*TBW-1:0] o_tag_bus;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NI-1:0]     v;
        logic [NI*DW-1:0]  d;
        logic [NI*TBW-1:0] t;
    } beat_t;

    beat_t sb[$];
    beat_t prev;
    bit    mon_en    = 1'b0;
    bit    prev_hold = 1'b0;
    int    cyc       = 0;
    int    acc_cnt   = 0;
    int    out_cycles[$];

    always #5 clk = ~clk;

    dst_tag_expand4multicast_pipe #(
        .DATA_WIDTH      (DW),
        .NUM_INPUT_DATA  (NI),
        .NUM_OUTPUT_DATA (NO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_cmd      (i_cmd),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_tag_bus  (o_tag_bus),
        .o_ready    (o_ready)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Node (l,p) is reached iff, at every level above it, the router on the
    // path either multicasts or its index bit equals the path's branch bit.
    function automatic logic [NI*TBW-1:0] model_tags(input logic [NI-1:0] v, input logic [CW-1:0] cmd);
        logic [NI*TBW-1:0] r;
        logic [D-1:0]      idx;
        logic [D-1:0]      mask;
        bit                on;
        bit                pb;
        int                b;
        r = '0;
        for (int k = 0; k < NI; k++) begin
            idx  = cmd[k*2*D +: D];
            mask = cmd[k*2*D + D +: D];
            if (v[k]) begin
                for (int l = 0; l < D; l++) begin
                    for (int p = 0; p < (1 << l); p++) begin
                        on = 1'b1;
                        for (int j = 0; j < l; j++) begin
                            b  = D - 1 - j;
                            pb = ((p >> (l - 1 - j)) & 1) != 0;
                            if (!mask[b] && (idx[b] != pb)) on = 1'b0;
                        end
                        if (on) begin
                            b = D - 1 - l;
                            r[k*TBW + 2*((1 << l) - 1 + p) +: 2] =
                                mask[b] ? 2'b11 : (idx[b] ? 2'b10 : 2'b01);
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [NI*DW-1:0] model_data(input logic [NI-1:0] v, input logic [NI*DW-1:0] d);
        logic [NI*DW-1:0] r;
        r = '0;
        for (int k = 0; k < NI; k++) if (v[k]) r[k*DW +: DW] = d[k*DW +: DW];
        return r;
    endfunction

    function automatic logic [NI*DW-1:0] rand_data();
        logic [NI*DW-1:0] r;
        for (int k = 0; k < NI; k++) r[k*DW +: DW] = 32'($urandom);
        return r;
    endfunction

    function automatic logic [CW-1:0] rand_cmd();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // Monitor: every cycle compare the DUT against the queue of beats in
    // flight, then account for the transfers the next edge will perform.
    always @(negedge clk) begin
        logic  exp_rdy;
        logic  consumed;
        beat_t nb;
        cyc++;
        if (mon_en) begin
            exp_rdy = i_en && !rst && (sb.size() < D || o_ready);
            check("i_ready", 256'(i_ready), 256'(exp_rdy));
            if (o_valid != '0) begin
                if (sb.size() == 0) begin
                    check("orphan_out", 256'(o_valid), 256'(0));
                end else begin
                    check("out_valid", 256'(o_valid), 256'(sb[0].v));
                    check("out_data", 256'(o_data_bus), 256'(sb[0].d));
                    check("out_tags", 256'(o_tag_bus), 256'(sb[0].t));
                end
            end else begin
                check("idle_data", 256'(o_data_bus), 256'(0));
                check("idle_tags", 256'(o_tag_bus), 256'(0));
            end
            if (prev_hold) begin
                check("hold_valid", 256'(o_valid), 256'(prev.v));
                check("hold_data", 256'(o_data_bus), 256'(prev.d));
                check("hold_tags", 256'(o_tag_bus), 256'(prev.t));
            end
            if (rst) begin
                sb.delete();
                prev_hold = 1'b0;
            end else begin
                consumed = (o_valid != '0) && o_ready && i_en;
                if (consumed) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    out_cycles.push_back(cyc);
                end
                if (exp_rdy && (i_valid != '0)) begin
                    nb.v = i_valid;
                    nb.d = model_data(i_valid, i_data_bus);
                    nb.t = model_tags(i_valid, i_cmd);
                    sb.push_back(nb);
                    acc_cnt++;
                end
                prev_hold = (o_valid != '0) && !consumed;
                prev.v    = o_valid;
                prev.d    = o_data_bus;
                prev.t    = o_tag_bus;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [NI-1:0] v, input logic [NI*DW-1:0] d, input logic [CW-1:0] c);
        i_valid    = v;
        i_data_bus = d;
        i_cmd      = c;
    endtask

    task automatic idle_in();
        set_beat('0, '0, '0);
    endtask

    task automatic drain(input string name);
        o_ready = 1'b1;
        i_en    = 1'b1;
        idle_in();
        for (int c = 0; c < 20 && (sb.size() != 0 || o_valid != '0); c++) step();
        check(name, 256'(sb.size()), 256'(0));
    endtask

    // Drive one beat and confirm it surfaces exactly D edges after acceptance
    task automatic send_one(input string name, input logic [NI-1:0] v, input logic [NI*DW-1:0] d,
                            input logic [CW-1:0] c);
        o_ready = 1'b1;
        set_beat(v, d, c);
        step();
        idle_in();
        for (int e = 1; e < D; e++) begin
            @(negedge clk);
            check({name, "_early"}, 256'(o_valid), 256'(0));
            step();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [NI*TBW-1:0] snap_t;
        logic [NI*DW-1:0]  snap_d;
        logic [NI-1:0]     snap_v;
        int                a0;

        rst     = 1'b1;
        i_en    = 1'b1;
        o_ready = 1'b1;
        idle_in();

        // Pin the model against hand-derived tag sets
        check("model_idx5", 256'(model_tags(8'h01, 48'h5) & 112'h3FFF), 256'(14'h0812));
        check("model_m001", 256'(model_tags(8'h08, 48'(8) << 18) >> (3*TBW)), 256'(14'h00C5));
        check("model_bcast", 256'(model_tags(8'h08, 48'(6'h3A) << 18) >> (3*TBW)), 256'(14'h3FFF));

        step();
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_i_ready", 256'(i_ready), 256'(0));
        check("rst_o_valid", 256'(o_valid), 256'(0));
        check("rst_tags", 256'(o_tag_bus), 256'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 256'(i_ready), 256'(1));

        // Single unicast beat on lane 0
        step();
        send_one("t1", 8'h01, 256'hA5A5A5A5, 48'h5);
        check("t1_valid", 256'(o_valid), 256'(8'h01));
        check("t1_tags0", 256'(o_tag_bus[0 +: TBW]), 256'(14'h0812));
        check("t1_tags_rest", 256'(o_tag_bus[NI*TBW-1:TBW]), 256'(0));
        check("t1_data0", 256'(o_data_bus[0 +: DW]), 256'(32'hA5A5A5A5));
        check("t1_data_rest", 256'(o_data_bus[NI*DW-1:DW]), 256'(0));

        // Partial multicast and broadcast on lane 3
        step();
        send_one("t2a", 8'h08, 256'(32'h1234_5678) << (3*DW), 48'(8) << 18);
        check("t2a_tags3", 256'(o_tag_bus[3*TBW +: TBW]), 256'(14'h00C5));
        check("t2a_data3", 256'(o_data_bus[3*DW +: DW]), 256'(32'h1234_5678));
        step();
        send_one("t2b", 8'h08, 256'(32'hCAFE_F00D) << (3*DW), 48'(6'h3A) << 18);
        check("t2b_tags3", 256'(o_tag_bus[3*TBW +: TBW]), 256'(14'h3FFF));

        // Back-to-back beats at full rate
        drain("t3_pre_drain");
        out_cycles.delete();
        for (int b = 0; b < 8; b++) begin
            set_beat(8'($urandom_range(1, 255)), rand_data(), rand_cmd());
            @(negedge clk);
            check("t3_i_ready", 256'(i_ready), 256'(1));
            step();
        end
        idle_in();
        repeat (6) step();
        check("t3_out_count", 256'(out_cycles.size()), 256'(8));
        if (out_cycles.size() == 8)
            check("t3_consecutive", 256'(out_cycles[7] - out_cycles[0]), 256'(7));

        // Output stall: only D beats fit, outputs frozen while stalled
        drain("t4_pre_drain");
        o_ready = 1'b0;
        a0      = acc_cnt;
        snap_t  = '0;
        snap_d  = '0;
        for (int c = 0; c < 8; c++) begin
            set_beat(8'($urandom_range(1, 255)), rand_data(), rand_cmd());
            if (c >= 3) begin
                @(negedge clk);
                check("t4_stall_rdy", 256'(i_ready), 256'(0));
                if (c == 3) begin
                    snap_t = o_tag_bus;
                    snap_d = o_data_bus;
                end
            end
            step();
        end
        check("t4_accepts", 256'(acc_cnt - a0), 256'(3));
        check("t4_tags_stable", 256'(o_tag_bus), 256'(snap_t));
        check("t4_data_stable", 256'(o_data_bus), 256'(snap_d));
        drain("t4_drain");

        // Global enable dropped mid-stream
        snap_v = '0;
        snap_t = '0;
        for (int c = 0; c < 10; c++) begin
            set_beat(8'($urandom_range(1, 255)), rand_data(), rand_cmd());
            i_en = (c >= 3 && c < 7) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (c == 3) begin
                snap_v = o_valid;
                snap_t = o_tag_bus;
            end
            if (c >= 3 && c < 7) begin
                check("t5_en_rdy", 256'(i_ready), 256'(0));
                check("t5_frozen_valid", 256'(o_valid), 256'(snap_v));
                check("t5_frozen_tags", 256'(o_tag_bus), 256'(snap_t));
            end
            step();
        end
        drain("t5_drain");

        // Reset with two beats in flight
        set_beat(8'h81, rand_data(), rand_cmd());
        step();
        set_beat(8'h42, rand_data(), rand_cmd());
        step();
        idle_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_o_valid", 256'(o_valid), 256'(0));
        check("t6_tags", 256'(o_tag_bus), 256'(0));
        check("t6_data", 256'(o_data_bus), 256'(0));
        check("t6_i_ready", 256'(i_ready), 256'(1));
        step();
        set_beat(8'h11, rand_data(), rand_cmd());
        step();
        set_beat(8'hF0, rand_data(), rand_cmd());
        step();
        drain("t6_drain");

        // Randomised traffic with stalls, freezes and occasional resets
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom % 50) == 0;
            i_en    = ($urandom % 8) != 0;
            o_ready = ($urandom % 4) != 0;
            if (($urandom % 4) == 0) set_beat('0, rand_data(), rand_cmd());
            else                     set_beat(8'($urandom), rand_data(), rand_cmd());
            step();
        end
        rst = 1'b0;
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
